sub_irq_ctrl: RTL and testbench

Sub-CPU interrupt controller for the Mega-CD mapper. It latches the six sub-CPU interrupt sources, including the level-3 pulse from the 8030 timer, and gates them through the interrupt-mask register at 0x032. It presents the highest pending level on the 68000 IPL lines and answers the interrupt-acknowledge cycle with an autovector (VPA). It sits between the source blocks and the `cpu` instance's `ipl`/`vpa` inputs, in the `clk_asic` domain, advancing only on `sub_sync`.

---
 rtl/mcd_pkg.sv | 9 +
 rtl/irq_prio_enc.sv | 16 +
 rtl/sub_irq_ctrl.sv | 88 ++++++++
 tb/tb_sub_irq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcd_pkg.sv
// rtl/mcd_pkg.sv - shared Mega-CD mapper constants and types
package mcd_pkg;

    localparam logic [8:0] REG_IMASK = 9'h032;
    localparam logic [2:0] FC_IACK   = 3'b111;

    typedef enum logic {IRQ_IDLE, IRQ_ACK} irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational highest-set-bit encoder, req bit k-1 is level k
module irq_prio_enc #(
    parameter int N = 6
) (
    input  logic [N-1:0] req,
    output logic [2:0]   lvl
);

    always_comb begin
        lvl = 3'd0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) lvl = 3'(i + 1);
        end
    end

endmodule

// File: rtl/sub_irq_ctrl.sv
// rtl/sub_irq_ctrl.sv - sub-CPU interrupt controller: edge latch, mask, priority, autovector IACK
module sub_irq_ctrl
    import mcd_pkg::*;
#(
    parameter int         N_SRC     = 6,
    parameter logic [8:0] REG_IMASK = mcd_pkg::REG_IMASK
) (
    input  logic             clk_asic,
    input  logic             rst_n,
    input  logic             sub_sync,
    input  logic [14:0]      reg_addr,
    input  logic [15:0]      sub_data,
    input  logic             regs_we_lo_sub,
    input  logic             regs_we_hi_sub,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [2:0]       cpu_fc,
    input  logic             cpu_as_n,
    input  logic [2:0]       cpu_addr,
    output logic [2:0]       ipl_n,
    output logic             vpa_n,
    output logic [15:0]      reg_8032_do
);

    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] ack_clr;
    logic [2:0]       ipl_q;
    logic [2:0]       lvl;
    logic             vpa_q, vpa_d;
    logic             iack_go;
    irq_state_t       state_q, state_d;

    logic unused_bits;
    assign unused_bits = ^{sub_data[15:N_SRC+1], sub_data[0], regs_we_hi_sub};

    irq_prio_enc #(.N(N_SRC)) u_prio (
        .req (pend_q),
        .lvl (lvl)
    );

    always_comb begin
        mask_d = mask_q;
        if (regs_we_lo_sub && reg_addr == {6'b0, REG_IMASK}) mask_d = sub_data[N_SRC:1];

        iack_go = (state_q == IRQ_IDLE) && (cpu_fc == FC_IACK) && !cpu_as_n && (cpu_addr != 3'd0);
        for (int k = 0; k < N_SRC; k++) begin
            ack_clr[k] = iack_go && (cpu_addr == 3'(k + 1));
        end

        // Masking with the new mask last makes a same-tick mask clear beat a new rise,
        // while a new rise still beats the acknowledge clear.
        pend_d = ((pend_q & ~ack_clr) | (irq_src & ~src_q)) & mask_d;

        state_d = state_q;
        vpa_d   = vpa_q;
        if (iack_go) begin
            state_d = IRQ_ACK;
            vpa_d   = 1'b0;
        end else if (state_q == IRQ_ACK && cpu_as_n) begin
            state_d = IRQ_IDLE;
            vpa_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_asic or negedge rst_n) begin
        if (!rst_n) begin
            mask_q  <= '0;
            pend_q  <= '0;
            src_q   <= '0;
            ipl_q   <= 3'b111;
            vpa_q   <= 1'b1;
            state_q <= IRQ_IDLE;
        end else if (sub_sync) begin
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            src_q   <= irq_src;
            ipl_q   <= ~lvl;
            vpa_q   <= vpa_d;
            state_q <= state_d;
        end
    end

    assign ipl_n       = ipl_q;
    assign vpa_n       = vpa_q;
    assign reg_8032_do = 16'({mask_q, 1'b0});

endmodule

// File: tb/tb_sub_irq_ctrl.sv
// tb/tb_sub_irq_ctrl.sv - self-checking bench for sub_irq_ctrl
module tb_sub_irq_ctrl;

    logic        clk_asic = 1'b0;
    logic        rst_n = 1'b0;
    logic        sub_sync = 1'b0;
    logic [14:0] reg_addr = '0;
    logic [15:0] sub_data = '0;
    logic        regs_we_lo_sub = 1'b0;
    logic        regs_we_hi_sub = 1'b0;
    logic [5:0]  irq_src = '0;
    logic [2:0]  cpu_fc = '0;
    logic        cpu_as_n = 1'b1;
    logic [2:0]  cpu_addr = '0;
    logic [2:0]  ipl_n;
    logic        vpa_n;
    logic [15:0] reg_8032_do;

    int checks = 0;
    int errors = 0;

    // reference model state, indexed by interrupt level 1..6
    bit       m_mask [1:6];
    bit       m_pend [1:6];
    bit [5:0] m_prev;
    bit       m_in_ack;
    int       m_ipl_lvl;
    bit       m_vpa;

    sub_irq_ctrl dut (
        .clk_asic       (clk_asic),
        .rst_n          (rst_n),
        .sub_sync       (sub_sync),
        .reg_addr       (reg_addr),
        .sub_data       (sub_data),
        .regs_we_lo_sub (regs_we_lo_sub),
        .regs_we_hi_sub (regs_we_hi_sub),
        .irq_src        (irq_src),
        .cpu_fc         (cpu_fc),
        .cpu_as_n       (cpu_as_n),
        .cpu_addr       (cpu_addr),
        .ipl_n          (ipl_n),
        .vpa_n          (vpa_n),
        .reg_8032_do    (reg_8032_do)
    );

    always #5 clk_asic = ~clk_asic;

    task automatic model_reset();
        for (int k = 1; k <= 6; k++) begin
            m_mask[k] = 0;
            m_pend[k] = 0;
        end
        m_prev = '0;
        m_in_ack = 0;
        m_ipl_lvl = 0;
        m_vpa = 1;
    endtask

    task automatic model_step();
        bit new_mask [1:6];
        int hi;
        bit iack;
        bit rise;
        hi = 0;
        for (int k = 1; k <= 6; k++) begin
            new_mask[k] = m_mask[k];
            if (m_pend[k]) hi = k;
        end
        if (regs_we_lo_sub && reg_addr == 15'h032)
            for (int k = 1; k <= 6; k++) new_mask[k] = sub_data[k];
        iack = !m_in_ack && cpu_fc == 3'b111 && !cpu_as_n && cpu_addr != 0;
        for (int k = 1; k <= 6; k++) begin
            rise = irq_src[k-1] && !m_prev[k-1];
            if (iack && int'(cpu_addr) == k) m_pend[k] = 0;
            if (rise && new_mask[k]) m_pend[k] = 1;
            if (!new_mask[k]) m_pend[k] = 0;
            m_mask[k] = new_mask[k];
        end
        m_prev = irq_src;
        m_ipl_lvl = hi;
        if (iack) begin
            m_vpa = 0;
            m_in_ack = 1;
        end else if (m_in_ack && cpu_as_n) begin
            m_vpa = 1;
            m_in_ack = 0;
        end
    endtask

    function automatic logic [15:0] model_rdback();
        logic [15:0] v;
        v = '0;
        for (int k = 1; k <= 6; k++) v[k] = m_mask[k];
        return v;
    endfunction

    // one sub_sync tick, preceded by a random number of idle clocks
    task automatic tick();
        sub_sync = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk_asic);
        sub_sync = 1'b1;
        @(negedge clk_asic);
        sub_sync = 1'b0;
        model_step();
    endtask

    task automatic do_reset();
        @(negedge clk_asic);
        rst_n = 1'b0;
        reg_addr = '0; sub_data = '0; regs_we_lo_sub = 0; regs_we_hi_sub = 0;
        irq_src = '0; cpu_fc = '0; cpu_as_n = 1'b1; cpu_addr = '0;
        repeat (2) @(negedge clk_asic);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic write_mask(input logic [15:0] v);
        reg_addr = 15'h032; sub_data = v; regs_we_lo_sub = 1'b1;
        tick();
        regs_we_lo_sub = 1'b0; sub_data = '0; reg_addr = '0;
    endtask

    task automatic iack_start(input logic [2:0] a);
        cpu_fc = 3'b111; cpu_as_n = 1'b0; cpu_addr = a;
        tick();
    endtask

    task automatic iack_end();
        cpu_as_n = 1'b1; cpu_fc = 3'b000; cpu_addr = 3'd0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ipl_n !== 3'b111) begin errors++; $display("FAIL reset_ipl: got %b expected 111", ipl_n); end
        checks++; if (vpa_n !== 1'b1) begin errors++; $display("FAIL reset_vpa: got %b expected 1", vpa_n); end
        checks++; if (reg_8032_do !== 16'h0000) begin errors++; $display("FAIL reset_rdback: got %h expected 0000", reg_8032_do); end
    endtask

    task automatic test_basic();
        write_mask(16'h0008);
        checks++; if (reg_8032_do !== 16'h0008) begin errors++; $display("FAIL basic_rdback: got %h expected 0008", reg_8032_do); end
        irq_src = 6'b000100; tick();
        checks++; if (ipl_n !== 3'b111) begin errors++; $display("FAIL basic_lat1: got %b expected 111", ipl_n); end
        irq_src = '0; tick();
        checks++; if (ipl_n !== 3'b100) begin errors++; $display("FAIL basic_lat2: got %b expected 100", ipl_n); end
        iack_start(3'd3);
        checks++; if (vpa_n !== 1'b0) begin errors++; $display("FAIL basic_vpa_lo: got %b expected 0", vpa_n); end
        tick();
        checks++; if (ipl_n !== 3'b111) begin errors++; $display("FAIL basic_cleared: got %b expected 111", ipl_n); end
        iack_end();
        checks++; if (vpa_n !== 1'b1) begin errors++; $display("FAIL basic_vpa_hi: got %b expected 1", vpa_n); end
    endtask

    task automatic test_masked_drop();
        write_mask(16'h0000);
        irq_src = 6'b010000; tick();
        irq_src = '0; tick();
        write_mask(16'h0020);
        tick(); tick();
        checks++; if (ipl_n !== 3'b111) begin errors++; $display("FAIL masked_drop_ipl: got %b expected 111", ipl_n); end
        checks++; if (reg_8032_do !== 16'h0020) begin errors++; $display("FAIL masked_drop_rdback: got %h expected 0020", reg_8032_do); end
    endtask

    task automatic test_priority();
        write_mask(16'h007E);
        irq_src = 6'b100010; tick();
        irq_src = '0; tick();
        checks++; if (ipl_n !== 3'b001) begin errors++; $display("FAIL prio_top: got %b expected 001", ipl_n); end
        iack_start(3'd6);
        checks++; if (vpa_n !== 1'b0) begin errors++; $display("FAIL prio_vpa: got %b expected 0", vpa_n); end
        tick();
        checks++; if (ipl_n !== 3'b101) begin errors++; $display("FAIL prio_next: got %b expected 101", ipl_n); end
        iack_end();
        iack_start(3'd2);
        iack_end();
        checks++; if (ipl_n !== 3'b111) begin errors++; $display("FAIL prio_drain: got %b expected 111", ipl_n); end
    endtask

    task automatic test_set_beats_clear();
        irq_src = 6'b001000; tick();
        irq_src = '0; tick();
        checks++; if (ipl_n !== 3'b011) begin errors++; $display("FAIL setclr_pre: got %b expected 011", ipl_n); end
        irq_src = 6'b001000;
        iack_start(3'd4);
        irq_src = '0;
        tick();
        checks++; if (ipl_n !== 3'b011) begin errors++; $display("FAIL setclr_kept: got %b expected 011", ipl_n); end
        iack_end();
        checks++; if (vpa_n !== 1'b1) begin errors++; $display("FAIL setclr_vpa: got %b expected 1", vpa_n); end
        iack_start(3'd4);
        iack_end();
        checks++; if (ipl_n !== 3'b111) begin errors++; $display("FAIL setclr_drain: got %b expected 111", ipl_n); end
    endtask

    task automatic test_spurious();
        irq_src = 6'b010000; tick();
        irq_src = '0; tick();
        iack_start(3'd1);
        checks++; if (vpa_n !== 1'b0) begin errors++; $display("FAIL spur_vpa_lo: got %b expected 0", vpa_n); end
        tick();
        checks++; if (ipl_n !== 3'b010) begin errors++; $display("FAIL spur_pend: got %b expected 010", ipl_n); end
        iack_end();
        checks++; if (vpa_n !== 1'b1) begin errors++; $display("FAIL spur_vpa_hi: got %b expected 1", vpa_n); end
        iack_start(3'd5);
        iack_end();
    endtask

    task automatic test_mask_clear_wins();
        irq_src = 6'b000100;
        write_mask(16'h0076);
        irq_src = '0;
        tick(); tick();
        checks++; if (ipl_n !== 3'b111) begin errors++; $display("FAIL mclr_ipl: got %b expected 111", ipl_n); end
        reg_addr = 15'h032; sub_data = 16'h0000; regs_we_hi_sub = 1'b1;
        tick();
        regs_we_hi_sub = 1'b0;
        checks++; if (reg_8032_do !== 16'h0076) begin errors++; $display("FAIL hi_only_write: got %h expected 0076", reg_8032_do); end
        write_mask(16'hFFFF);
        checks++; if (reg_8032_do !== 16'h007E) begin errors++; $display("FAIL rdback_bits: got %h expected 007e", reg_8032_do); end
    endtask

    task automatic test_hold();
        irq_src = 6'b000001;
        cpu_fc = 3'b111; cpu_as_n = 1'b0; cpu_addr = 3'd1;
        repeat (5) @(negedge clk_asic);
        checks++; if (ipl_n !== 3'b111 || vpa_n !== 1'b1) begin errors++; $display("FAIL hold: got ipl %b vpa %b expected 111 1", ipl_n, vpa_n); end
        tick();
        checks++; if (vpa_n !== 1'b0) begin errors++; $display("FAIL hold_iack: got %b expected 0", vpa_n); end
        irq_src = '0; tick();
        checks++; if (ipl_n !== 3'b110) begin errors++; $display("FAIL hold_set: got %b expected 110", ipl_n); end
        iack_end();
        iack_start(3'd1);
        iack_end();
        checks++; if (ipl_n !== 3'b111) begin errors++; $display("FAIL hold_drain: got %b expected 111", ipl_n); end
    endtask

    task automatic test_reset_mid_ack();
        write_mask(16'h007E);
        irq_src = 6'b010000; tick();
        irq_src = '0; tick();
        iack_start(3'd5);
        @(negedge clk_asic);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (vpa_n !== 1'b1) begin errors++; $display("FAIL rst_ack_vpa: got %b expected 1", vpa_n); end
        checks++; if (ipl_n !== 3'b111) begin errors++; $display("FAIL rst_ack_ipl: got %b expected 111", ipl_n); end
        checks++; if (reg_8032_do !== 16'h0000) begin errors++; $display("FAIL rst_ack_rdback: got %h expected 0000", reg_8032_do); end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 300; n++) begin
            irq_src = 6'($urandom_range(0, 63));
            regs_we_lo_sub = ($urandom_range(0, 3) == 0);
            regs_we_hi_sub = ($urandom_range(0, 3) == 0);
            reg_addr = ($urandom_range(0, 3) != 0) ? 15'h032 : 15'($urandom);
            sub_data = 16'($urandom);
            cpu_fc = ($urandom_range(0, 3) != 0) ? 3'b111 : 3'($urandom);
            cpu_as_n = m_in_ack ? ($urandom_range(0, 2) == 0) : 1'($urandom);
            cpu_addr = 3'($urandom);
            tick();
            checks++; if (ipl_n !== 3'(7 - m_ipl_lvl)) begin errors++; $display("FAIL rand_ipl[%0d]: got %b expected %b", n, ipl_n, 3'(7 - m_ipl_lvl)); end
            checks++; if (vpa_n !== m_vpa) begin errors++; $display("FAIL rand_vpa[%0d]: got %b expected %b", n, vpa_n, m_vpa); end
            checks++; if (reg_8032_do !== model_rdback()) begin errors++; $display("FAIL rand_rdback[%0d]: got %h expected %h", n, reg_8032_do, model_rdback()); end
        end
        regs_we_lo_sub = 0; regs_we_hi_sub = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_masked_drop();
        test_priority();
        test_set_beats_clear();
        test_spurious();
        test_mask_clear_wins();
        test_hold();
        test_reset_mid_ack();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
